// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt sequencer.
package pic_pkg;

    typedef enum logic [2:0] {IDLE, PEND, ACK1, GAP, ACK2} state_t;

    typedef logic [2:0] level_t;

    localparam int unsigned SPURIOUS_DEFAULT = 7;

    // Vector byte presented on the second acknowledge: T7..T3 from ICW2, level below.
    function automatic logic [7:0] vec_byte(input logic [4:0] base, input level_t lvl);
        return {base, lvl};
    endfunction

    // Distance from the current highest-priority slot; 0 is the most urgent.
    function automatic level_t prio_rank(input level_t lvl, input level_t lowest_prio);
        return level_t'(lvl - lowest_prio - 3'd1);
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Circular priority encoder: finds the most urgent set bit of req given the
// current lowest-priority level.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  level_t     lowest_prio,
    output logic       found,
    output level_t     level
);

    logic [7:0] rot;
    level_t     first;

    // rot[0] holds the highest-priority slot, rot[7] the lowest.
    always_comb begin
        rot = '0;
        for (int i = 0; i < 8; i++) begin
            rot[i] = req[level_t'(lowest_prio + level_t'(i + 1))];
        end
    end

    always_comb begin
        first = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                first = level_t'(i);
            end
        end
    end

    assign found = |rot;
    assign level = level_t'(first + lowest_prio + 3'd1);

endmodule

// File: rtl/pic_irq_sequencer.sv
// 8259 interrupt control core: IRR capture, mask/priority resolution against ISR,
// INT/INTA handshake sequencing, vector output and EOI/rotation handling.
module pic_irq_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SPURIOUS_LEVEL = SPURIOUS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir_in,
    input  logic       inta_n,
    input  logic       cfg_init,
    input  logic       cfg_ltim,
    input  logic       cfg_aeoi,
    input  logic [4:0] cfg_vec_base,
    input  logic [7:0] imr,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    output logic       int_out,
    output logic [7:0] vec_data,
    output logic       vec_oe,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] inta_sync;
    logic                   inta_d;
    logic                   inta_fall, inta_rise;
    logic [7:0]             ir_prev;
    level_t                 lowest_prio, lowest_prio_next;
    level_t                 ack_level, ack_level_next;
    logic                   spurious, spurious_next;
    logic [7:0]             ack_set, aeoi_clr, eoi_clr;
    logic [7:0]             irr_next, isr_next;
    logic                   req_found, isr_found, req_valid;
    level_t                 req_lvl, isr_lvl, eoi_lvl;

    // inta_n is asynchronous to clk; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_sync <= '1;
            inta_d    <= 1'b1;
        end else begin
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
            inta_d    <= inta_sync[SYNC_STAGES-1];
        end
    end

    assign inta_fall = inta_d & ~inta_sync[SYNC_STAGES-1];
    assign inta_rise = ~inta_d & inta_sync[SYNC_STAGES-1];

    pic_priority_resolver u_req_res (
        .req         (irr & ~imr),
        .lowest_prio (lowest_prio),
        .found       (req_found),
        .level       (req_lvl)
    );

    pic_priority_resolver u_isr_res (
        .req         (isr),
        .lowest_prio (lowest_prio),
        .found       (isr_found),
        .level       (isr_lvl)
    );

    // Fully nested: a request counts only if it outranks everything in service.
    assign req_valid = req_found &
                       (~isr_found | (prio_rank(req_lvl, lowest_prio) < prio_rank(isr_lvl, lowest_prio)));

    always_comb begin
        state_next     = state;
        ack_level_next = ack_level;
        spurious_next  = spurious;
        ack_set        = '0;
        aeoi_clr       = '0;
        case (state)
            IDLE: if (req_valid) state_next = PEND;
            PEND: begin
                if (inta_fall) begin
                    state_next     = ACK1;
                    ack_level_next = req_valid ? req_lvl : level_t'(SPURIOUS_LEVEL);
                    spurious_next  = ~req_valid;
                    if (req_valid) ack_set = 8'(1) << req_lvl;
                end else if (!req_valid) begin
                    state_next = IDLE;
                end
            end
            ACK1: if (inta_rise) state_next = GAP;
            GAP:  if (inta_fall) state_next = ACK2;
            ACK2: begin
                if (inta_rise) begin
                    state_next = IDLE;
                    if (cfg_aeoi && !spurious) aeoi_clr = 8'(1) << ack_level;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // EOI: an empty ISR suppresses both the clear and the rotation.
    always_comb begin
        eoi_clr          = '0;
        eoi_lvl          = eoi_specific ? level_t'(eoi_level) : isr_lvl;
        lowest_prio_next = lowest_prio;
        if (eoi_valid && (isr != '0)) begin
            eoi_clr = 8'(1) << eoi_lvl;
            if (eoi_rotate) lowest_prio_next = eoi_lvl;
        end
    end

    always_comb begin
        if (cfg_ltim) irr_next = ir_in & ~ack_set;
        else          irr_next = (irr | (ir_in & ~ir_prev)) & ir_in & ~ack_set;
        isr_next = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            irr         <= '0;
            isr         <= '0;
            ir_prev     <= '0;
            lowest_prio <= 3'd7;
            ack_level   <= '0;
            spurious    <= 1'b0;
            int_out     <= 1'b0;
            vec_oe      <= 1'b0;
            vec_data    <= '0;
        end else if (cfg_init) begin
            state       <= IDLE;
            irr         <= '0;
            isr         <= '0;
            ir_prev     <= '0;
            lowest_prio <= 3'd7;
            ack_level   <= '0;
            spurious    <= 1'b0;
            int_out     <= 1'b0;
            vec_oe      <= 1'b0;
            vec_data    <= '0;
        end else begin
            state       <= state_next;
            irr         <= irr_next;
            isr         <= isr_next;
            ir_prev     <= ir_in;
            lowest_prio <= lowest_prio_next;
            ack_level   <= ack_level_next;
            spurious    <= spurious_next;
            int_out     <= (state_next == PEND);
            vec_oe      <= (state_next == ACK2);
            vec_data    <= (state_next == ACK2) ? vec_byte(cfg_vec_base, ack_level_next) : '0;
        end
    end

endmodule

// File: tb/tb_pic_irq_sequencer.sv
// Directed scenarios plus randomized edge-mode traffic checked against a
// transaction-level priority model.
module tb_pic_irq_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir_in = '0;
    logic       inta_n = 1'b1;
    logic       cfg_init = 1'b0;
    logic       cfg_ltim = 1'b0;
    logic       cfg_aeoi = 1'b0;
    logic [4:0] cfg_vec_base = 5'b01000;
    logic [7:0] imr = '0;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       eoi_rotate = 1'b0;
    logic       int_out;
    logic [7:0] vec_data;
    logic       vec_oe;
    logic [7:0] irr;
    logic [7:0] isr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pic_irq_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_in        (ir_in),
        .inta_n       (inta_n),
        .cfg_init     (cfg_init),
        .cfg_ltim     (cfg_ltim),
        .cfg_aeoi     (cfg_aeoi),
        .cfg_vec_base (cfg_vec_base),
        .imr          (imr),
        .eoi_valid    (eoi_valid),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .eoi_rotate   (eoi_rotate),
        .int_out      (int_out),
        .vec_data     (vec_data),
        .vec_oe       (vec_oe),
        .irr          (irr),
        .isr          (isr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Full two-pulse acknowledge; samples the bus while the second pulse is low.
    task automatic inta_service(output logic [7:0] vec, output logic oe_low,
                                output logic oe_after, output logic int_after_fall);
        inta_n = 1'b0; tick(4);
        int_after_fall = int_out;
        inta_n = 1'b1; tick(4);
        inta_n = 1'b0; tick(4);
        vec    = vec_data;
        oe_low = vec_oe;
        inta_n = 1'b1; tick(4);
        oe_after = vec_oe;
    endtask

    task automatic send_eoi(input logic spec, input logic [2:0] lvl, input logic rot);
        eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl; eoi_rotate = rot;
        tick(1);
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
        tick(1);
    endtask

    // Reference model: circular priority, highest level = (lp+1) mod 8.
    function automatic int pick(input logic [7:0] v, input int lp);
        for (int k = 1; k <= 8; k++) begin
            int l = (lp + k) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int rank(input int l, input int lp);
        return (l - lp - 1 + 16) % 8;
    endfunction

    logic [7:0] vec;
    logic       oe_low, oe_after, int_fall;
    logic [7:0] m_isr, r, mk, exp_vec;
    int         m_lp, cand, top, clr;
    logic       exp_valid, aeoi, spec, rot;
    logic [2:0] lvl;

    initial begin
        do_reset();
        check_val("rst_irr", 32'(irr), 32'h0);
        check_val("rst_isr", 32'(isr), 32'h0);
        check_val("rst_int", 32'(int_out), 32'h0);
        check_val("rst_oe", 32'(vec_oe), 32'h0);
        check_val("rst_vec", 32'(vec_data), 32'h0);

        // Single edge request on IR3, latency and vector.
        ir_in = 8'h08;
        tick(1); check_val("lat_1clk", 32'(int_out), 32'h0);
        tick(1); check_val("lat_2clk", 32'(int_out), 32'h1);
        inta_service(vec, oe_low, oe_after, int_fall);
        check_val("ir3_int_fall", 32'(int_fall), 32'h0);
        check_val("ir3_vec", 32'(vec), 32'h43);
        check_val("ir3_oe_low", 32'(oe_low), 32'h1);
        check_val("ir3_oe_after", 32'(oe_after), 32'h0);
        check_val("ir3_isr", 32'(isr), 32'h08);
        check_val("ir3_irr", 32'(irr), 32'h00);
        send_eoi(1'b0, 3'd0, 1'b0);
        check_val("ir3_eoi", 32'(isr), 32'h00);
        ir_in = 8'h00; tick(2);

        // IR2 and IR5 together.
        ir_in = 8'h24; tick(2);
        inta_service(vec, oe_low, oe_after, int_fall);
        check_val("ir25_vec_a", 32'(vec), 32'h42);
        check_val("ir25_isr_a", 32'(isr), 32'h04);
        check_val("ir25_irr_a", 32'(irr), 32'h20);
        send_eoi(1'b0, 3'd0, 1'b0);
        check_val("ir25_isr_eoi", 32'(isr), 32'h00);
        check_val("ir25_int_b", 32'(int_out), 32'h1);
        inta_service(vec, oe_low, oe_after, int_fall);
        check_val("ir25_vec_b", 32'(vec), 32'h45);
        send_eoi(1'b0, 3'd0, 1'b0);
        ir_in = 8'h00; tick(2);

        // Request withdrawn before INTA.
        ir_in = 8'h10; tick(2);
        check_val("wd_int_hi", 32'(int_out), 32'h1);
        ir_in = 8'h00; tick(2);
        check_val("wd_int_lo", 32'(int_out), 32'h0);

        // Request withdrawn exactly as the synchronised INTA fall arrives: spurious.
        ir_in = 8'h10; tick(2);
        inta_n = 1'b0; tick(1);
        ir_in = 8'h00; tick(3);
        check_val("sp_int", 32'(int_out), 32'h0);
        inta_n = 1'b1; tick(4);
        inta_n = 1'b0; tick(4);
        check_val("sp_vec", 32'(vec_data), 32'h47);
        check_val("sp_oe", 32'(vec_oe), 32'h1);
        inta_n = 1'b1; tick(4);
        check_val("sp_isr", 32'(isr), 32'h00);
        check_val("sp_oe_after", 32'(vec_oe), 32'h0);

        // Rotation after servicing IR0.
        do_reset();
        ir_in = 8'h01; tick(2);
        inta_service(vec, oe_low, oe_after, int_fall);
        check_val("rot_vec0", 32'(vec), 32'h40);
        send_eoi(1'b0, 3'd0, 1'b1);
        check_val("rot_isr0", 32'(isr), 32'h00);
        ir_in = 8'h00; tick(2);
        ir_in = 8'h03; tick(2);
        inta_service(vec, oe_low, oe_after, int_fall);
        check_val("rot_vec1", 32'(vec), 32'h41);
        check_val("rot_isr1", 32'(isr), 32'h02);
        send_eoi(1'b0, 3'd0, 1'b0);
        ir_in = 8'h00; tick(3);

        // Auto-EOI.
        do_reset();
        cfg_aeoi = 1'b1;
        ir_in = 8'h08; tick(2);
        inta_service(vec, oe_low, oe_after, int_fall);
        check_val("aeoi_vec", 32'(vec), 32'h43);
        check_val("aeoi_isr", 32'(isr), 32'h00);
        ir_in = 8'h00; tick(2);

        // Soft init in the gap between acknowledge pulses.
        ir_in = 8'h08; tick(2);
        inta_n = 1'b0; tick(4);
        inta_n = 1'b1; tick(4);
        check_val("init_isr_pre", 32'(isr), 32'h08);
        cfg_init = 1'b1; ir_in = 8'h00; tick(1);
        cfg_init = 1'b0; tick(1);
        check_val("init_irr", 32'(irr), 32'h00);
        check_val("init_isr", 32'(isr), 32'h00);
        check_val("init_int", 32'(int_out), 32'h0);
        inta_n = 1'b0; tick(4);
        check_val("init_oe", 32'(vec_oe), 32'h0);
        inta_n = 1'b1; tick(4);

        // Level mode with auto-EOI: held line re-raises INT.
        cfg_ltim = 1'b1;
        ir_in = 8'h40; tick(2);
        check_val("lvl_int", 32'(int_out), 32'h1);
        inta_service(vec, oe_low, oe_after, int_fall);
        check_val("lvl_vec", 32'(vec), 32'h46);
        check_val("lvl_isr", 32'(isr), 32'h00);
        check_val("lvl_reint", 32'(int_out), 32'h1);
        ir_in = 8'h00; tick(3);
        check_val("lvl_drop", 32'(int_out), 32'h0);
        cfg_ltim = 1'b0; cfg_aeoi = 1'b0;

        // Randomized edge-mode traffic against the model.
        do_reset();
        m_isr = '0;
        m_lp  = 7;
        for (int it = 0; it < 40; it++) begin
            r    = 8'($urandom);
            mk   = 8'($urandom) & 8'($urandom);
            aeoi = 1'($urandom);
            cfg_vec_base = 5'($urandom);
            imr = mk; cfg_aeoi = aeoi; ir_in = r;
            tick(3);
            check_val("rnd_irr", 32'(irr), 32'(r));
            cand = pick(r & ~mk, m_lp);
            top  = pick(m_isr, m_lp);
            exp_valid = (cand >= 0) && ((top < 0) || (rank(cand, m_lp) < rank(top, m_lp)));
            check_val("rnd_int", 32'(int_out), 32'(exp_valid));
            if (exp_valid) begin
                inta_service(vec, oe_low, oe_after, int_fall);
                exp_vec = {cfg_vec_base, 3'(cand)};
                check_val("rnd_vec", 32'(vec), 32'(exp_vec));
                check_val("rnd_oe", 32'(oe_low), 32'h1);
                if (!aeoi) m_isr[cand] = 1'b1;
                check_val("rnd_isr_ack", 32'(isr), 32'(m_isr));
                check_val("rnd_irr_ack", 32'(irr), 32'(r & ~(8'h01 << cand)));
            end
            if (($urandom % 3) != 0) begin
                spec = 1'($urandom);
                lvl  = 3'($urandom);
                rot  = 1'($urandom);
                if (m_isr != '0) begin
                    clr = spec ? int'(lvl) : pick(m_isr, m_lp);
                    m_isr[clr] = 1'b0;
                    if (rot) m_lp = clr;
                end
                send_eoi(spec, lvl, rot);
                check_val("rnd_isr_eoi", 32'(isr), 32'(m_isr));
            end
            ir_in = 8'h00;
            tick(3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
